// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer driving an external 1-bit full-adder cell.
// Optional zero flag output when SERIAL_ADDSUB_ZERO_FLAG_EN is defined.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        last    = 1'b0;
        fa_a    = 1'b0;
        fa_b    = 1'b0;
        fa_cin  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                fa_a   = a_sh[0];
                fa_b   = b_sh[0];
                fa_cin = carry;
                if (cnt == LAST) begin
                    last    = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

    // Subtract is folded in at accept: b is inverted and carry seeded with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh  <= a_in;
            b_sh  <= op ? ~b_in : b_in;
            carry <= op;
            cnt   <= '0;
        end else if (state == S_SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= (WIDTH-1)'({fa_s, sum_sh} >> 1);
            carry  <= fa_cout;
            cnt    <= cnt + 1'b1;
            if (last) begin
                result   <= {fa_s, sum_sh};
                cout     <= fa_cout;
                overflow <= fa_cin ^ fa_cout;
            end
        end
    end

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic zacc;

    always_ff @(posedge clk) begin
        if (rst) begin
            zacc <= 1'b0;
            zero <= 1'b0;
        end else if (accept) begin
            zacc <= 1'b0;
        end else if (state == S_SHIFT) begin
            zacc <= zacc | fa_s;
            if (last) zero <= ~(zacc | fa_s);
        end
    end
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl with a behavioural full-adder cell.
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         fa_a, fa_b, fa_cin, fa_s, fa_cout;
    logic         busy, done, cout, overflow;
    logic [W-1:0] result;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic         zero;
`endif

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_s(fa_s), .fa_cout(fa_cout),
        .busy(busy), .done(done), .result(result),
        .cout(cout), .overflow(overflow)
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
        int           at;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic o);
        exp_t e;
        logic [W:0] s;
        if (!o) s = {1'b0, a} + {1'b0, b};
        else    s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        e.r = s[W-1:0];
        e.c = s[W];
        if (!o) e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
        else    e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
        e.z  = (e.r == '0);
        e.at = 0;
        return e;
    endfunction

    // Carry into bit i of a + bb + o, from the low i bits only.
    function automatic logic cin_at(input logic [W-1:0] a,
                                    input logic [W-1:0] bb,
                                    input logic o, input int i);
        logic [W-1:0] m;
        logic [W:0]   s;
        m = (W'(1) << i) - W'(1);
        s = {1'b0, a & m} + {1'b0, bb & m} + (W+1)'(o);
        return s[i];
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.at));
                chk("result", 32'(result), 32'(e.r));
                chk("cout", 32'(cout), 32'(e.c));
                chk("overflow", 32'(overflow), 32'(e.v));
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
                chk("zero", 32'(zero), 32'(e.z));
`endif
            end
        end
    end

    // rst_at: -1 for a normal op, else the shift bit during which reset hits.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic o, input bit hold, input int rst_at);
        exp_t         e;
        logic [W-1:0] bb;
        bb = o ? ~b : b;
        @(posedge clk);
        #1;
        a_in  = a;
        b_in  = b;
        op    = o;
        start = 1'b1;
        e     = model(a, b, o);
        e.at  = cyc + 1 + W;
        if (rst_at < 0) q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        op   = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("busy_shift", 32'(busy), 32'd1);
            chk("fa_a", 32'(fa_a), 32'(a[i]));
            chk("fa_b", 32'(fa_b), 32'(bb[i]));
            chk("fa_cin", 32'(fa_cin), 32'(cin_at(a, bb, o, i)));
            if (i == rst_at) begin
                rst   = 1'b1;
                start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_result", 32'(result), 32'd0);
                chk("rst_cout", 32'(cout), 32'd0);
                chk("rst_ovf", 32'(overflow), 32'd0);
                chk("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
                return;
            end
        end
        @(negedge clk);
        chk("busy_end", 32'(busy), 32'd0);
        chk("fa_idle", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", 32'({cout, overflow}), 32'd0);
        chk("reset_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        chk("reset_zero", 32'(zero), 32'd0);
`endif
        rst = 1'b0;

        run_op(8'h05, 8'h03, 1'b0, 1'b0, -1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, -1);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, -1);
        run_op(8'h80, 8'h01, 1'b1, 1'b0, -1);
        run_op(8'h05, 8'h07, 1'b1, 1'b0, -1);
        run_op(8'h10, 8'h20, 1'b0, 1'b1, -1);
        run_op(8'h5F, 8'h33, 1'b0, 1'b0, 3);
        run_op(8'h10, 8'h10, 1'b1, 1'b0, -1);
        run_op(8'h00, 8'h00, 1'b0, 1'b0, -1);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   1'($urandom), -1);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
